// File: rtl/megarom_pkg.sv
// Shared types and address constants for the multi-mode MegaROM mapper.
// Holds the mapper mode enum, FSM states, write window and SCC window codes.
package megarom_pkg;

    typedef enum logic [2:0] {
        M_KONAMI  = 3'd0,
        M_KSCC    = 3'd1,
        M_ASCII8  = 3'd2,
        M_ASCII16 = 3'd3,
        M_PLAIN   = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_REQ,
        S_HOLD
    } state_t;

    // Konami-SCC bank windows are x000h-x7FFh of each bank: ADDR[12:11]
    localparam logic [1:0]  KSCC_SEL  = 2'b10;
    // ASCII8 windows 6000h-7FFFh: ADDR[15:13]
    localparam logic [2:0]  A8_WIN    = 3'b011;
    // ASCII16 windows 6000h-67FFh / 7000h-77FFh: ADDR[15:11]
    localparam logic [4:0]  A16_WIN0  = 5'b01100;
    localparam logic [4:0]  A16_WIN1  = 5'b01110;
    // SCC windows 9800h-9FFFh / B800h-BFFFh: ADDR[15:11]
    localparam logic [4:0]  SCC_WIN   = 5'b10011;
    localparam logic [4:0]  SCCI_WIN  = 5'b10111;
    localparam logic [5:0]  SCC_BANK  = 6'h3F;
    localparam logic [15:0] MREG_ADDR = 16'hBFFE;

    function automatic mode_t to_mode(input logic [2:0] m);
        case (m)
            3'd0:    return M_KONAMI;
            3'd1:    return M_KSCC;
            3'd2:    return M_ASCII8;
            3'd3:    return M_ASCII16;
            default: return M_PLAIN;
        endcase
    endfunction

endpackage

// File: rtl/megarom_bank_regs.sv
// Bank registers, write-window decode and SCC-I mode register.
// Ports: wr strobe + addr/din from the decode cycle; bank values, RAM write enables, mode-reg hit, SCC-I flag.
module megarom_bank_regs
    import megarom_pkg::*;
#(
    parameter int BANK_BITS = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic [2:0]                 MODE,
    input  logic                       SCC_I_ENA,
    input  logic                       wr,
    input  logic [15:0]                addr,
    input  logic [7:0]                 din,
    output logic [3:0][BANK_BITS-1:0]  bank,
    output logic [3:0]                 bank_we,
    output logic                       mreg_hit,
    output logic                       scc_mode_i
);

    mode_t                      md;
    logic                       active;
    logic [5:0]                 mreg;
    logic [3:0]                 upd;
    logic [1:0]                 idx;
    logic [1:0]                 tgt;
    logic                       win;
    logic                       pair;
    logic [3:0][BANK_BITS-1:0]  rst_val;

    assign md       = to_mode(MODE);
    assign idx      = {addr[15], addr[13]};
    assign active   = (md == M_KSCC) && SCC_I_ENA;
    assign mreg_hit = active && (addr[15:1] == MREG_ADDR[15:1]);

    // D4 opens every bank for RAM writes; D0..D2 open banks 1..3
    assign bank_we    = active ? {mreg[4] | mreg[2], mreg[4] | mreg[1],
                                  mreg[4] | mreg[0], mreg[4]} : 4'b0000;
    assign upd        = ~bank_we;
    assign scc_mode_i = active && mreg[5];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (md)
                M_ASCII8:  rst_val[i] = '0;
                M_ASCII16: rst_val[i] = BANK_BITS'(i % 2);
                default:   rst_val[i] = BANK_BITS'(i);
            endcase
        end
    end

    always_comb begin
        win  = 1'b0;
        tgt  = idx;
        pair = 1'b0;
        case (md)
            M_KONAMI: win = (idx != 2'd0);
            M_KSCC:   win = (addr[12:11] == KSCC_SEL);
            M_ASCII8: begin
                win = (addr[15:13] == A8_WIN);
                tgt = addr[12:11];
            end
            M_ASCII16: begin
                win  = (addr[15:11] == A16_WIN0) || (addr[15:11] == A16_WIN1);
                tgt  = {addr[12], 1'b0};
                pair = 1'b1;
            end
            default: win = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            bank <= rst_val;
            mreg <= '0;
        end else if (wr) begin
            if (mreg_hit) begin
                mreg <= din[5:0];
            end else if (win && upd[tgt]) begin
                if (pair) begin
                    bank[tgt]             <= BANK_BITS'({din, 1'b0});
                    bank[{tgt[1], 1'b1}]  <= BANK_BITS'({din, 1'b1});
                end else begin
                    bank[tgt] <= BANK_BITS'(din);
                end
            end
        end
    end

endmodule

// File: rtl/megarom_multimapper.sv
// Multi-mode MegaROM mapper: slot decode, bank mapping, RAM req/ack and SCC select.
// Ports: MSX bus strobes/ADDR/DIN in, DOUT/BUSDIR_n out; RAM req/ack side; SCC_CS_n, SCC_MODE_I, BANK_REG.
module megarom_multimapper
    import megarom_pkg::*;
#(
    parameter int                    BANK_BITS  = 8,
    parameter int                    RAM_ADDR_W = 23,
    parameter logic [RAM_ADDR_W-1:0] RAM_BASE   = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_n,
    input  logic [2:0]               MODE,
    input  logic                     SCC_I_ENA,
    input  logic [BANK_BITS-1:0]     BANK_MASK,
    input  logic                     SLTSL_n,
    input  logic                     MERQ_n,
    input  logic                     RD_n,
    input  logic                     WR_n,
    input  logic [15:0]              ADDR,
    input  logic [7:0]               DIN,
    output logic [7:0]               DOUT,
    output logic                     BUSDIR_n,
    output logic                     RAM_REQ,
    output logic                     RAM_WE,
    output logic [RAM_ADDR_W-1:0]    RAM_ADDR,
    output logic [7:0]               RAM_DIN,
    input  logic                     RAM_ACK,
    input  logic [7:0]               RAM_DOUT,
    output logic                     SCC_CS_n,
    output logic                     SCC_MODE_I,
    output logic [4*BANK_BITS-1:0]   BANK_REG
);

    state_t                     state, state_n;
    mode_t                      md;
    logic                       access, acc_q, start;
    logic                       rd_q;
    logic [1:0]                 idx;
    logic [3:0][BANK_BITS-1:0]  bank;
    logic [3:0]                 bank_we;
    logic                       mreg_hit;
    logic                       scc_hit;
    logic                       need_ram;
    logic                       ack_ok;
    logic [BANK_BITS-1:0]       mbank;
    logic [RAM_ADDR_W-1:0]      off;

    assign md     = to_mode(MODE);
    assign idx    = {ADDR[15], ADDR[13]};
    assign access = !SLTSL_n && !MERQ_n && (!RD_n || !WR_n) &&
                    (ADDR[15:14] == 2'b01 || ADDR[15:14] == 2'b10);
    assign start  = access && !acc_q;

    megarom_bank_regs #(
        .BANK_BITS (BANK_BITS)
    ) u_regs (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .MODE       (MODE),
        .SCC_I_ENA  (SCC_I_ENA),
        .wr         (state == S_DECODE && access && !WR_n),
        .addr       (ADDR),
        .din        (DIN),
        .bank       (bank),
        .bank_we    (bank_we),
        .mreg_hit   (mreg_hit),
        .scc_mode_i (SCC_MODE_I)
    );

    assign BANK_REG = bank;

    always_comb begin
        scc_hit = 1'b0;
        if (md == M_KSCC) begin
            if (SCC_MODE_I)
                scc_hit = (ADDR[15:11] == SCCI_WIN) && bank[3][7];
            else
                scc_hit = (ADDR[15:11] == SCC_WIN) && (bank[2][5:0] == SCC_BANK);
        end
    end

    // Register and blocked writes finish on the bus side only
    assign need_ram = access && !scc_hit &&
                      (!RD_n || (bank_we[idx] && !mreg_hit));

    assign mbank = bank[idx] & BANK_MASK;
    assign off   = RAM_ADDR_W'({mbank, ADDR[12:0]});

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_DECODE;
            S_DECODE: state_n = need_ram ? S_REQ : S_HOLD;
            S_REQ:    if (RAM_ACK) state_n = access ? S_HOLD : S_IDLE;
            S_HOLD:   if (!access) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Read data is only handed to the bus if the access is still open
    assign ack_ok = (state == S_REQ) && RAM_ACK && rd_q && access;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            acc_q    <= 1'b0;
            rd_q     <= 1'b0;
            RAM_REQ  <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DIN  <= '0;
            DOUT     <= '0;
            BUSDIR_n <= 1'b1;
            SCC_CS_n <= 1'b1;
        end else begin
            acc_q    <= access;
            SCC_CS_n <= !(access && scc_hit);
            if (state == S_DECODE) begin
                rd_q <= !RD_n;
                if (need_ram) begin
                    RAM_REQ  <= 1'b1;
                    RAM_WE   <= RD_n;
                    RAM_ADDR <= RAM_BASE + off;
                    RAM_DIN  <= DIN;
                end
            end
            if (state == S_REQ && RAM_ACK) begin
                RAM_REQ <= 1'b0;
                RAM_WE  <= 1'b0;
            end
            if (ack_ok) begin
                DOUT     <= RAM_DOUT;
                BUSDIR_n <= 1'b0;
            end
            if (state == S_HOLD && !access) begin
                DOUT     <= '0;
                BUSDIR_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_megarom_multimapper.sv
// Directed bench for megarom_multimapper with a RAM responder and request scoreboard.
// Expected RAM transactions are queued at stimulus time and checked when RAM_REQ rises.
module tb_megarom_multimapper;

    localparam logic [22:0] BASE = 23'h100000;

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  din;
    } rq_t;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic [2:0]  MODE;
    logic        SCC_I_ENA;
    logic [7:0]  BANK_MASK;
    logic        SLTSL_n, MERQ_n, RD_n, WR_n;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        BUSDIR_n;
    logic        RAM_REQ, RAM_WE;
    logic [22:0] RAM_ADDR;
    logic [7:0]  RAM_DIN;
    logic        RAM_ACK = 1'b0;
    logic [7:0]  RAM_DOUT = 8'h00;
    logic        SCC_CS_n, SCC_MODE_I;
    logic [31:0] BANK_REG;

    int  total = 0;
    int  bad = 0;
    int  ack_delay = 0;
    int  cnt = 0;
    int  req_cnt = 0;
    bit  seen = 0;
    rq_t exp_q[$];

    always #5 CLK = ~CLK;

    megarom_multimapper #(
        .BANK_BITS  (8),
        .RAM_ADDR_W (23),
        .RAM_BASE   (BASE)
    ) dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .MODE       (MODE),
        .SCC_I_ENA  (SCC_I_ENA),
        .BANK_MASK  (BANK_MASK),
        .SLTSL_n    (SLTSL_n),
        .MERQ_n     (MERQ_n),
        .RD_n       (RD_n),
        .WR_n       (WR_n),
        .ADDR       (ADDR),
        .DIN        (DIN),
        .DOUT       (DOUT),
        .BUSDIR_n   (BUSDIR_n),
        .RAM_REQ    (RAM_REQ),
        .RAM_WE     (RAM_WE),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_DIN    (RAM_DIN),
        .RAM_ACK    (RAM_ACK),
        .RAM_DOUT   (RAM_DOUT),
        .SCC_CS_n   (SCC_CS_n),
        .SCC_MODE_I (SCC_MODE_I),
        .BANK_REG   (BANK_REG)
    );

    function automatic logic [7:0] mdata(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [22:0] raddr(input logic [7:0] b, input logic [15:0] a);
        return BASE + {2'b00, b, a[12:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // RAM model: scoreboard check on the first REQ cycle, ACK after ack_delay
    always @(negedge CLK) begin
        if (RAM_REQ === 1'b1) begin
            if (!seen) begin
                rq_t e;
                seen = 1;
                req_cnt++;
                chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ram_addr", 32'(RAM_ADDR), 32'(e.addr));
                    chk("ram_we", 32'(RAM_WE), 32'(e.we));
                    chk("ram_din", 32'(RAM_DIN), 32'(e.din));
                end
            end
            if (!RAM_ACK) begin
                if (cnt >= ack_delay) begin
                    RAM_ACK  = 1'b1;
                    RAM_DOUT = mdata(RAM_ADDR);
                end else begin
                    cnt++;
                end
            end
        end else begin
            seen    = 0;
            cnt     = 0;
            RAM_ACK = 1'b0;
        end
    end

    task automatic idle_bus;
        SLTSL_n = 1'b1;
        MERQ_n  = 1'b1;
        RD_n    = 1'b1;
        WR_n    = 1'b1;
        ADDR    = 16'h0000;
        DIN     = 8'h00;
    endtask

    task automatic drive(input bit wr, input logic [15:0] a, input logic [7:0] d);
        SLTSL_n = 1'b0;
        MERQ_n  = 1'b0;
        ADDR    = a;
        DIN     = d;
        RD_n    = wr;
        WR_n    = !wr;
    endtask

    task automatic do_reset(input logic [2:0] m, input logic scci, input logic [7:0] mask);
        @(negedge CLK);
        RESET_n   = 1'b0;
        MODE      = m;
        SCC_I_ENA = scci;
        BANK_MASK = mask;
        idle_bus();
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic do_wr(input string tag, input logic [15:0] a, input logic [7:0] d,
                         input bit ram, input logic [22:0] ea);
        int c0;
        rq_t e;
        c0 = req_cnt;
        if (ram) begin
            e.we = 1'b1; e.addr = ea; e.din = d;
            exp_q.push_back(e);
        end
        @(negedge CLK);
        drive(1, a, d);
        repeat (6) @(negedge CLK);
        idle_bus();
        repeat (2) @(negedge CLK);
        chk({tag, "_reqs"}, 32'(req_cnt - c0), ram ? 32'd1 : 32'd0);
    endtask

    task automatic do_rd(input string tag, input logic [15:0] a, input logic [22:0] ea);
        int n;
        rq_t e;
        e.we = 1'b0; e.addr = ea; e.din = 8'h00;
        exp_q.push_back(e);
        @(negedge CLK);
        drive(0, a, 8'h00);
        n = 0;
        while (BUSDIR_n !== 1'b0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_busdir"}, 32'(BUSDIR_n), 32'd0);
        chk({tag, "_dout"}, 32'(DOUT), 32'(mdata(ea)));
        idle_bus();
        @(negedge CLK);
        chk({tag, "_busdir_off"}, 32'(BUSDIR_n), 32'd1);
        chk({tag, "_dout_off"}, 32'(DOUT), 32'd0);
    endtask

    task automatic do_scc(input string tag, input logic [15:0] a);
        int c0;
        c0 = req_cnt;
        @(negedge CLK);
        drive(0, a, 8'h00);
        repeat (3) @(negedge CLK);
        chk({tag, "_cs"}, 32'(SCC_CS_n), 32'd0);
        chk({tag, "_busdir"}, 32'(BUSDIR_n), 32'd1);
        idle_bus();
        @(negedge CLK);
        chk({tag, "_cs_off"}, 32'(SCC_CS_n), 32'd1);
        @(negedge CLK);
        chk({tag, "_noreq"}, 32'(req_cnt - c0), 32'd0);
    endtask

    initial begin
        int  n;
        int  c0;
        bit  low_seen;
        rq_t e;

        RESET_n   = 1'b0;
        MODE      = 3'd1;
        SCC_I_ENA = 1'b0;
        BANK_MASK = 8'hFF;
        idle_bus();
        repeat (2) @(negedge CLK);
        chk("rst_req", 32'(RAM_REQ), 32'd0);
        chk("rst_we", 32'(RAM_WE), 32'd0);
        chk("rst_addr", 32'(RAM_ADDR), 32'd0);
        chk("rst_din", 32'(RAM_DIN), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_busdir", 32'(BUSDIR_n), 32'd1);
        chk("rst_scc_cs", 32'(SCC_CS_n), 32'd1);
        chk("rst_scc_i", 32'(SCC_MODE_I), 32'd0);
        chk("rst_bank_kscc", BANK_REG, 32'h03020100);
        RESET_n = 1'b1;
        @(negedge CLK);

        // Konami-SCC bank write then mapped read
        do_wr("kscc_w9000", 16'h9000, 8'h05, 0, '0);
        chk("kscc_bank2", BANK_REG, 32'h03050100);
        do_rd("kscc_rd8123", 16'h8123, raddr(8'h05, 16'h8123));

        // SCC window with bank2 = 3Fh
        do_wr("kscc_w3f", 16'h9000, 8'h3F, 0, '0);
        chk("kscc_bank2_3f", BANK_REG, 32'h033F0100);
        do_scc("scc_9800", 16'h9800);

        // SCC-I mode register
        do_reset(3'd1, 1'b1, 8'hFF);
        do_wr("scci_wb000", 16'hB000, 8'h80, 0, '0);
        chk("scci_bank3", BANK_REG, 32'h80020100);
        do_wr("scci_mreg30", 16'hBFFE, 8'h30, 0, '0);
        chk("scci_mode_on", 32'(SCC_MODE_I), 32'd1);
        do_scc("scci_b800", 16'hB800);

        // Mode register 01h: bank1 RAM-writable, others update normally
        do_wr("mreg01", 16'hBFFF, 8'h01, 0, '0);
        chk("scci_mode_off", 32'(SCC_MODE_I), 32'd0);
        do_wr("ramw_7000", 16'h7000, 8'h44, 1, raddr(8'h01, 16'h7000));
        chk("ramw_bank1_kept", BANK_REG, 32'h80020100);
        do_wr("upd_9000", 16'h9000, 8'h22, 0, '0);
        chk("upd_bank2", BANK_REG, 32'h80220100);
        do_wr("blocked_4000", 16'h4000, 8'h11, 0, '0);

        // ASCII16
        do_reset(3'd3, 1'b0, 8'hFF);
        chk("rst_bank_a16", BANK_REG, 32'h01000100);
        do_wr("a16_w7000", 16'h7000, 8'h03, 0, '0);
        chk("a16_banks", BANK_REG, 32'h07060100);
        do_rd("a16_rda000", 16'hA000, raddr(8'h07, 16'hA000));

        // ASCII8
        do_reset(3'd2, 1'b0, 8'hFF);
        chk("rst_bank_a8", BANK_REG, 32'h00000000);
        do_wr("a8_w7800", 16'h7800, 8'h09, 0, '0);
        chk("a8_bank3", BANK_REG, 32'h09000000);
        do_rd("a8_rda010", 16'hA010, raddr(8'h09, 16'hA010));

        // Konami with ROM-size mask
        do_reset(3'd0, 1'b0, 8'h0F);
        chk("rst_bank_kon", BANK_REG, 32'h03020100);
        do_wr("kon_w6000", 16'h6000, 8'h23, 0, '0);
        chk("kon_bank1", BANK_REG, 32'h03022300);
        do_wr("kon_w4000", 16'h4000, 8'h55, 0, '0);
        chk("kon_bank0_fixed", BANK_REG, 32'h03022300);
        do_rd("kon_rd6123", 16'h6123, raddr(8'h03, 16'h6123));

        // Plain ROM
        do_reset(3'd4, 1'b0, 8'hFF);
        do_wr("plain_w6000", 16'h6000, 8'h09, 0, '0);
        chk("plain_bank", BANK_REG, 32'h03020100);
        do_rd("plain_rda000", 16'hA000, raddr(8'h03, 16'hA000));

        // Slow ACK with the read released early
        do_reset(3'd1, 1'b0, 8'hFF);
        ack_delay = 5;
        c0 = req_cnt;
        e.we = 1'b0; e.addr = raddr(8'h01, 16'h6010); e.din = 8'h00;
        exp_q.push_back(e);
        @(negedge CLK);
        drive(0, 16'h6010, 8'h00);
        repeat (2) @(negedge CLK);
        idle_bus();
        low_seen = 0;
        n = 0;
        do begin
            @(negedge CLK);
            if (BUSDIR_n === 1'b0) low_seen = 1;
            if (n == 2) chk("dly_req_held", 32'(RAM_REQ), 32'd1);
            n++;
        end while (RAM_REQ === 1'b1 && n < 30);
        chk("dly_no_timeout", 32'(n < 30), 32'd1);
        @(negedge CLK);
        chk("dly_busdir_never", 32'(low_seen), 32'd0);
        chk("dly_busdir", 32'(BUSDIR_n), 32'd1);
        chk("dly_dout", 32'(DOUT), 32'd0);
        chk("dly_reqs", 32'(req_cnt - c0), 32'd1);

        // Reset in the middle of a pending request
        ack_delay = 10;
        e.we = 1'b0; e.addr = raddr(8'h00, 16'h4020); e.din = 8'h00;
        exp_q.push_back(e);
        @(negedge CLK);
        drive(0, 16'h4020, 8'h00);
        n = 0;
        while (RAM_REQ !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_req_seen", 32'(RAM_REQ), 32'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(RAM_REQ), 32'd0);
        chk("mid_rst_addr", 32'(RAM_ADDR), 32'd0);
        chk("mid_rst_busdir", 32'(BUSDIR_n), 32'd1);
        chk("mid_rst_scc_cs", 32'(SCC_CS_n), 32'd1);
        chk("mid_rst_dout", 32'(DOUT), 32'd0);
        idle_bus();
        ack_delay = 0;
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
